// File: rtl/inv_mix_columns.sv
// inv_mix_columns: AES InvMixColumns over a 128-bit state with a
// valid/ready handshake on both sides.
//
// Byte layout: column c, row r lives at bits [c*32 + r*8 +: 8].
//
// Build option:
//   INV_MIX_PARALLEL_EN  defined   -> all four columns transformed in a
//                                     single BUSY cycle (result after 1 edge)
//                        undefined -> one shared column datapath stepped
//                                     over four cycles (result after 4 edges)
// Both builds produce identical results and follow the same handshake.
module inv_mix_columns (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
);

   // ------------------------------------------------------------------
   // GF(2^8) helpers (reduction polynomial x^8+x^4+x^3+x+1 -> 8'h1b)
   // ------------------------------------------------------------------

   // Multiply by x: shift left, fold the carried-out bit back in.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      logic [7:0] shifted;
      shifted = {b[6:0], 1'b0};
      if (b[7]) begin
         shifted = shifted ^ 8'h1b;
      end
      return shifted;
   endfunction

   // One column of InvMixColumns. Every coefficient (09, 0b, 0d, 0e) is a
   // sum of x^3, x^2, x and 1, so each input byte only needs its x2/x4/x8
   // multiples once; the four products are then xor combinations of them.
   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] s  [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [31:0] r;
      for (int k = 0; k < 4; k++) begin
         s[k]  = c[k*8 +: 8];
         x2[k] = xtime(s[k]);
         x4[k] = xtime(x2[k]);
         x8[k] = xtime(x4[k]);
         m9[k] = x8[k] ^ s[k];
         mb[k] = x8[k] ^ x2[k] ^ s[k];
         md[k] = x8[k] ^ x4[k] ^ s[k];
         me[k] = x8[k] ^ x4[k] ^ x2[k];
      end
      r[7:0]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      r[15:8]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      r[23:16] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      r[31:24] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      return r;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_reg;
   logic [127:0]  data_reg;
   logic          out_valid_reg;
   logic [127:0]  data_next;
   logic          busy_last;

`ifdef INV_MIX_PARALLEL_EN
   // ------------------------------------------------------------------
   // Parallel datapath: one column transform per column, all at once.
   // ------------------------------------------------------------------
   logic [127:0] par_result;

   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign par_result[gi*32 +: 32] = inv_col(data_reg[gi*32 +: 32]);
   end

   assign data_next = par_result;
   assign busy_last = 1'b1;
`else
   // ------------------------------------------------------------------
   // Serial datapath: a single column transform walks col 0..3 and the
   // result overwrites the column it came from.
   // ------------------------------------------------------------------
   logic [1:0]   col_reg;
   logic [31:0]  col_in;
   logic [31:0]  col_out;
   logic [127:0] ser_result;
   logic [31:0]  col_word [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign col_word[gi] = data_reg[gi*32 +: 32];
   end

   // Select the column currently being transformed.
   always_comb begin
      col_in = col_word[col_reg];
   end

   assign col_out = inv_col(col_in);

   // Splice the transformed column back into its own slot.
   always_comb begin
      ser_result = data_reg;
      ser_result[{col_reg, 5'd0} +: 32] = col_out;
   end

   assign data_next = ser_result;
   assign busy_last = (col_reg == 2'd3);
`endif

   // ------------------------------------------------------------------
   // Control FSM: capture, transform, hold result until it is taken.
   // A result retired in DONE while a new input is offered is replaced
   // by that input in the same edge so back-to-back blocks see no bubble.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         data_reg      <= 128'h0;
         out_valid_reg <= 1'b0;
`ifndef INV_MIX_PARALLEL_EN
         col_reg       <= 2'd0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  data_reg  <= in_state;
                  state_reg <= BUSY;
`ifndef INV_MIX_PARALLEL_EN
                  col_reg   <= 2'd0;
`endif
               end
            end
            BUSY: begin
               data_reg <= data_next;
`ifndef INV_MIX_PARALLEL_EN
               col_reg  <= col_reg + 2'd1;
`endif
               if (busy_last) begin
                  state_reg     <= DONE;
                  out_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  if (in_valid) begin
                     data_reg  <= in_state;
                     state_reg <= BUSY;
`ifndef INV_MIX_PARALLEL_EN
                     col_reg   <= 2'd0;
`endif
                  end else begin
                     state_reg <= IDLE;
                  end
               end
            end
            default: begin
               state_reg     <= IDLE;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign in_ready  = (state_reg == IDLE) | ((state_reg == DONE) & out_ready);
   assign out_valid = out_valid_reg;
   assign out_state = data_reg;

endmodule

// File: doc/inv_mix_columns.md
INV_MIX_COLUMNS -- requirements
Module: inv_mix_columns

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: in_state is valid this cycle.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept in_state this cycle.
REQ-005 SHALL have port in_state, input, 128 bits: AES state, column c row r at bits [c*32+r*8 +: 8].
REQ-006 SHALL have port out_valid, output, 1 bit: out_state holds a completed result.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts out_state this cycle.
REQ-008 SHALL have port out_state, output, 128 bits: InvMixColumns result, same byte layout as in_state.

Function
REQ-009 SHALL compute per column s'0=0e*s0^0b*s1^0d*s2^09*s3, s'1=09*s0^0e*s1^0b*s2^0d*s3, s'2=0d*s0^09*s1^0e*s2^0b*s3, s'3=0b*s0^0d*s1^09*s2^0e*s3, products in GF(2^8) modulo 8'h1b.
REQ-010 SHALL build GF multiplies from xtime (shift left 1, xor 8'h1b when the shifted-out bit is 1), evaluated on the operand byte, with 8-bit results only.
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-012 SHALL, on handshake in_valid&in_ready, capture in_state into an internal 128-bit register, clear column counter col to 0, and enter BUSY.
REQ-013 SHALL in BUSY transform column col per cycle, write it back in place, increment col (2 bits); on col==3 enter DONE.
REQ-014 SHALL assert out_valid only in DONE; result valid 4 cycles after the input handshake edge (handshake edge N, out_valid high after edge N+4).
REQ-015 SHALL hold out_state and out_valid stable while out_valid&!out_ready (backpressure).
REQ-016 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-017 SHALL, on DONE with out_ready and in_valid both high, retire the current result and capture the new input in the same cycle, going directly to BUSY with no idle bubble.
REQ-018 SHALL return to IDLE on DONE with out_ready high and in_valid low.
REQ-019 SHALL ignore in_valid and in_state while in BUSY (in_ready low).
REQ-020 SHALL present out_state as the internal register; its value is don't-care when out_valid is low.

Reset
REQ-021 SHALL, on rst high at any time including mid-BUSY, immediately force state=IDLE, col=0, internal register=128'h0, out_valid=0.
REQ-022 SHALL drive in_ready=1 and out_state=128'h0 while rst is high and after its release until the first handshake.
REQ-023 SHALL discard any partially transformed state on reset; no result is emitted for it.

Configuration
REQ-024 SHALL support macro INV_MIX_PARALLEL_EN.
REQ-025 With INV_MIX_PARALLEL_EN defined, SHALL transform all four columns in one BUSY cycle: out_valid high after edge N+1. Handshake rules are unchanged.
REQ-026 Without INV_MIX_PARALLEL_EN, SHALL use one shared column datapath iterated over 4 cycles as in REQ-013.
REQ-027 Results SHALL be bit-identical in both configurations.

Verification
REQ-028 Column 0 = 32'hbca14d8e, other columns 0, out_ready=1: column 0 of out_state = 32'h455313db (db 13 53 45); out_valid after edge N+4 (N+1 parallel).
REQ-029 All columns 32'h9d58dc9f: every column of out_state = 32'h5c220af2.
REQ-030 in_state all bytes 8'hc6, then all bytes 8'h01: out_state equals in_state in each case (fixed points).
REQ-031 out_ready held low 10 cycles after out_valid: out_state and out_valid stable and in_ready low; raise out_ready with in_valid high: next input accepted that edge and state goes to BUSY.
REQ-032 Assert rst 2 cycles after a handshake: out_valid=0, in_ready=1, out_state=0 immediately; no stale output after release.
REQ-033 Round trip: random states passed through MixColumns then this block return the original (1000 vectors, both configurations).
